// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the modular exponentiation controller.
package mod_exp_pkg;

  localparam int NBITS_DEF = 4;
  localparam int EBITS_DEF = 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SCAN     = 3'd1;
  localparam logic [2:0] S_NEXT     = 3'd2;
  localparam logic [2:0] S_SQR_REQ  = 3'd3;
  localparam logic [2:0] S_SQR_WAIT = 3'd4;
  localparam logic [2:0] S_MUL_REQ  = 3'd5;
  localparam logic [2:0] S_MUL_WAIT = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    SCAN     = S_SCAN,
    NEXT     = S_NEXT,
    SQR_REQ  = S_SQR_REQ,
    SQR_WAIT = S_SQR_WAIT,
    MUL_REQ  = S_MUL_REQ,
    MUL_WAIT = S_MUL_WAIT,
    DONE     = S_DONE
  } state_e;

  localparam int CNTW_DEF = $clog2(EBITS_DEF + 1);

  function automatic int cnt_w(input int ebits);
    return $clog2(ebits + 1);
  endfunction

endpackage

// File: rtl/mod_exp_bit_scan.sv
// Exponent shift register and remaining-bit counter.
module mod_exp_bit_scan
  import mod_exp_pkg::*;
#(
  parameter int EBITS = EBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [EBITS-1:0] exp_i,
  input  logic             shift_i,
  output logic             bit_o,
  output logic             last_o,
  output logic             zero_o
);

  localparam int CW = cnt_w(EBITS);

  logic [EBITS-1:0] exp_q, exp_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    exp_d = exp_q;
    cnt_d = cnt_q;
    if (load_i) begin
      exp_d = exp_i;
      cnt_d = CW'(EBITS);
    end else if (shift_i) begin
      exp_d = exp_q << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q <= '0;
      cnt_q <= '0;
    end else begin
      exp_q <= exp_d;
      cnt_q <= cnt_d;
    end
  end

  // bit_o is the bit that the next shift pushes out
  assign bit_o  = exp_q[EBITS-1];
  assign last_o = (cnt_q == CW'(1));
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving a shared
// modular multiplier.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int EBITS = EBITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             done_p,
  output logic             busy,
  output logic             err,
  output logic             mul_enable_p,
  output logic [NBITS-1:0] mul_a,
  output logic [NBITS-1:0] mul_b,
  output logic [NBITS-1:0] mul_m,
  input  logic [NBITS-1:0] mul_y,
  input  logic             mul_done_p
);

  state_e           state_q, state_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [NBITS-1:0] base_q, base_d;
  logic [NBITS-1:0] m_q, m_d;
  logic             cur_q, cur_d;
  logic             errp_q, errp_d;
  logic [NBITS-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             en_q, en_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] mm_q, mm_d;
  logic             load, shift;
  logic             sbit, slast, szero;

  mod_exp_bit_scan #(.EBITS(EBITS)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .exp_i   (exp),
    .shift_i (shift),
    .bit_o   (sbit),
    .last_o  (slast),
    .zero_o  (szero)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    base_d  = base_q;
    m_d     = m_q;
    cur_d   = cur_q;
    errp_d  = errp_q;
    res_d   = res_q;
    done_d  = 1'b0;
    err_d   = err_q;
    en_d    = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    mm_d    = mm_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_p) begin
          load   = 1'b1;
          base_d = base;
          m_d    = m;
          r_d    = base;
          err_d  = 1'b0;
          errp_d = 1'b0;
          state_d = SCAN;
          if (m == '0) begin
            errp_d  = 1'b1;
            r_d     = '0;
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        shift = 1'b1;
        if (sbit) begin
          state_d = NEXT;
        end else if (slast) begin
          // exp == 0: x^0 mod m is 1, except modulo 1
          r_d = (m_q == NBITS'(1)) ? '0 : NBITS'(1);
          state_d = DONE;
        end
      end
      NEXT: begin
        if (szero) begin
          state_d = DONE;
        end else begin
          shift   = 1'b1;
          cur_d   = sbit;
          state_d = SQR_REQ;
        end
      end
      SQR_REQ: begin
        a_d     = r_q;
        b_d     = r_q;
        mm_d    = m_q;
        en_d    = 1'b1;
        state_d = SQR_WAIT;
      end
      SQR_WAIT: begin
        if (mul_done_p) begin
          r_d     = mul_y;
          state_d = cur_q ? MUL_REQ : NEXT;
        end
      end
      MUL_REQ: begin
        a_d     = r_q;
        b_d     = base_q;
        mm_d    = m_q;
        en_d    = 1'b1;
        state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_done_p) begin
          r_d     = mul_y;
          state_d = NEXT;
        end
      end
      DONE: begin
        res_d   = r_q;
        done_d  = 1'b1;
        err_d   = errp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      base_q  <= '0;
      m_q     <= '0;
      cur_q   <= 1'b0;
      errp_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      base_q  <= base_d;
      m_q     <= m_d;
      cur_q   <= cur_d;
      errp_q  <= errp_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mm_q    <= mm_d;
    end
  end

  assign result       = res_q;
  assign done_p       = done_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;
  assign mul_enable_p = en_q;
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign mul_m        = mm_q;

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Left-to-right square-and-multiply controller computing result = base^exp mod m. It sits directly upstream of the interleaved modular multiplier (mod_mul_il_booth) and drives its enable/operand ports. It consumes the multiplier's y and completion pulse, so one mod-mul core is time-shared for a full modular exponentiation.

## Interface
- NBITS, 4: operand/modulus width; must equal the multiplier's NBITS.
- EBITS, 8: exponent width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_p  in  1  one-cycle start pulse; sampled only in IDLE.
- base  in  NBITS  base, precondition base < m; captured on start.
- exp  in  EBITS  exponent; captured on start.
- m  in  NBITS  modulus; captured on start.
- result  out  NBITS  base^exp mod m; valid from done_p onward, held until next done_p.
- done_p  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after start acceptance until the done_p cycle, exclusive.
- err  out  1  set with done_p when m == 0; cleared on next start.
- mul_enable_p  out  1  one-cycle multiplier start pulse, registered.
- mul_a, mul_b, mul_m  out  NBITS  multiplier operands, registered.
- mul_y  in  NBITS  multiplier product.
- mul_done_p  in  1  multiplier completion pulse.

## Operation
- States: IDLE, SCAN, NEXT, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE.
- IDLE: on start_p, latch base_loc, exp_loc, m_loc, cnt = EBITS, r = base_loc, err = 0.
  - If m == 0: set err = 1, r = 0, go to DONE.
  - Otherwise go to SCAN.
- SCAN: shift exp_loc left by one and decrement cnt each cycle.
  - If the shifted-out bit is 1, go to NEXT.
  - If cnt reaches 0 with no 1 found (exp == 0): r = (m_loc == 1) ? 0 : 1, go to DONE.
- NEXT: if cnt == 0, go to DONE. Otherwise shift exp_loc left, decrement cnt, latch cur_bit = shifted-out bit, go to SQR_REQ.
- SQR_REQ: mul_a = mul_b = r, mul_m = m_loc, pulse mul_enable_p, go to SQR_WAIT.
- SQR_WAIT: on mul_done_p, r = mul_y. Go to MUL_REQ if cur_bit, else to NEXT.
- MUL_REQ: mul_a = r, mul_b = base_loc, mul_m = m_loc, pulse mul_enable_p, go to MUL_WAIT.
- MUL_WAIT: on mul_done_p, r = mul_y, go to NEXT.
- DONE: result = r, done_p = 1 for one cycle, go to IDLE.
- Multiplication count = (index of MSB set in exp) + popcount(exp) − 1.
- mul_a/mul_b/mul_m are held stable from the mul_enable_p cycle until mul_done_p is accepted, because the multiplier samples them over multiple cycles.
- mul_done_p outside SQR_WAIT/MUL_WAIT is ignored.
- start_p outside IDLE is ignored; no queuing.
- m == 1 with exp ≠ 0: base < m forces base = 0, and the normal path yields 0.

## Timing
- Reset values: result = 0, done_p = 0, busy = 0, err = 0, mul_enable_p = 0, mul_a/b/m = 0, state = IDLE.
- The start_p sampling edge is edge 0. busy is high from edge 0 until the edge that asserts done_p.
- SCAN takes (EBITS − index of MSB set) edges. exp == 0 takes EBITS edges.
- The exp == 0 path has done_p high after edge EBITS+1.
- The m == 0 path has done_p high after edge 1.
- Each squaring or multiplication step costs 1 REQ cycle + multiplier latency + 1 edge to accept mul_done_p. Each NEXT visit costs 1 cycle.
- No fixed multiplier latency is assumed.
- Reset mid-operation: all registers return to reset values immediately. A stale mul_done_p afterwards is ignored. The multiplier itself is reset by the same event; the top level derives rst_n = ~rst.

## Structure
- Shared package mod_exp_pkg holds:
  - the state encoding localparams (3-bit);
  - default NBITS/EBITS;
  - the cnt width, $clog2(EBITS+1).
- Optional sub-module mod_exp_bit_scan holds the exp_loc shift register, cnt, and MSB-found/cur_bit outputs. The FSM and datapath stay in mod_exp_ctrl.
- The bench wraps mod_exp_ctrl with mod_mul_il_booth (PBITS = 1).

## Test plan
- NBITS = 8, EBITS = 8, base = 3, exp = 5, m = 7 -> result = 5, exactly 3 mul_enable_p pulses (sqr, sqr, mul), err = 0.
- base = 4, exp = 0, m = 13 -> result = 1, zero mul_enable_p, done_p after edge 9, busy high edges 0..8.
- base = 0, exp = 0, m = 1 -> result = 0. base = 0, exp = 3, m = 1 -> result = 0 with 2 mul pulses.
- m = 0, any base/exp -> done_p after edge 1, err = 1, result = 0, no mul_enable_p.
- base = 2, exp = 255, m = 251 -> result = 32, 14 mul_enable_p pulses. A start_p issued mid-run is ignored and the result is unchanged.
- Assert rst during SQR_WAIT -> all outputs 0 next cycle. A subsequent mul_done_p is ignored. A new start with base = 3, exp = 5, m = 7 returns 5.
